// File: rtl/hazard_pkg.sv
// Shared types, default latencies and the load-use predicate for the
// pipeline hazard controller and anything that checks decoder behaviour.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hazard_state_t;

  localparam int MUL_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF = 32;

  // Register indices are zero-extended to this width before comparing, so one
  // predicate serves every register-file size up to 256 entries.
  localparam int REG_ADDR_W_MAX  = 8;

  // True when the ID instruction reads the register a load in EX is about to
  // write. x0 is never a real dependency.
  function automatic logic is_load_use(
    input logic                      mem_read,
    input logic [REG_ADDR_W_MAX-1:0] ex_rd,
    input logic [REG_ADDR_W_MAX-1:0] id_rs1,
    input logic                      uses_rs1,
    input logic [REG_ADDR_W_MAX-1:0] id_rs2,
    input logic                      uses_rs2
  );
    return mem_read && (ex_rd != {REG_ADDR_W_MAX{1'b0}}) &&
           ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID and EX stages.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic [REG_ADDR_W_MAX-1:0] rs1_ext_s;
  logic [REG_ADDR_W_MAX-1:0] rs2_ext_s;
  logic [REG_ADDR_W_MAX-1:0] rd_ext_s;

  assign rs1_ext_s = REG_ADDR_W_MAX'(id_rs1);
  assign rs2_ext_s = REG_ADDR_W_MAX'(id_rs2);
  assign rd_ext_s  = REG_ADDR_W_MAX'(ex_rd);

  assign load_use = is_load_use(ex_mem_read, rd_ext_s, rs1_ext_s, id_uses_rs1,
                                rs2_ext_s, id_uses_rs2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, multi-cycle
// mul/div occupancy of EX and taken-branch squashes. Control outputs respond
// in the same cycle as their inputs; only the FSM and counters are registered.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_UsesRs1,
  input  logic                  ID_UsesRs2,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_MulDiv,
  input  logic                  EX_IsDiv,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Stall,
  output logic                  IF_ID_Stall,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  ID_EX_Stall,
  output logic                  EX_MEM_Bubble,
  output logic                  MulDivStart,
  output logic                  MulDivDone,
  output logic [CNT_W-1:0]      StallCount
);

  // The down-counter must hold LATENCY-1 for whichever op is longer.
  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int MD_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [MD_W-1:0]  MUL_RELOAD = MD_W'(MUL_LATENCY - 1);
  localparam logic [MD_W-1:0]  DIV_RELOAD = DIV_W_RELOAD_FIX(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  function automatic logic [MD_W-1:0] DIV_W_RELOAD_FIX(input int lat);
    return MD_W'(lat - 1);
  endfunction

  hazard_state_t   state_r;
  hazard_state_t   state_nxt_s;
  logic [MD_W-1:0] md_cnt_r;
  logic [MD_W-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0] stall_count_r;

  logic load_use_s;
  logic pc_stall_s;
  logic if_id_stall_s;
  logic if_id_flush_s;
  logic id_ex_bubble_s;
  logic id_ex_stall_s;
  logic ex_mem_bubble_s;
  logic md_start_s;
  logic md_done_s;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (ID_Rs1),
    .id_rs2      (ID_Rs2),
    .id_uses_rs1 (ID_UsesRs1),
    .id_uses_rs2 (ID_UsesRs2),
    .ex_mem_read (EX_MemRead),
    .ex_rd       (EX_Rd),
    .load_use    (load_use_s)
  );

  // Hazard decode: pick this cycle's stall/flush response and the next FSM state.
  always_comb begin
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_bubble_s  = 1'b0;
    id_ex_stall_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    md_start_s      = 1'b0;
    md_done_s       = 1'b0;
    state_nxt_s     = state_r;
    md_cnt_nxt_s    = md_cnt_r;
    if (rst) begin
      // Everything is held quiet while in reset; the registers clear below.
      state_nxt_s  = RUN;
      md_cnt_nxt_s = {MD_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (EX_MulDiv) begin
            // EX becomes occupied: freeze the front end, keep ID/EX held
            // rather than bubbled, and feed NOPs into MEM.
            md_start_s      = 1'b1;
            pc_stall_s      = 1'b1;
            if_id_stall_s   = 1'b1;
            id_ex_stall_s   = 1'b1;
            ex_mem_bubble_s = 1'b1;
            state_nxt_s     = MD_WAIT;
            md_cnt_nxt_s    = EX_IsDiv ? DIV_RELOAD : MUL_RELOAD;
          end else if (EX_BranchTaken) begin
            // The squash wins over load-use: the dependent instruction is
            // on the wrong path anyway.
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
          end else if (load_use_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MD_WAIT: begin
          if (md_cnt_r != {MD_W{1'b0}}) begin
            pc_stall_s      = 1'b1;
            if_id_stall_s   = 1'b1;
            id_ex_stall_s   = 1'b1;
            ex_mem_bubble_s = 1'b1;
            md_cnt_nxt_s    = md_cnt_r - MD_W'(1);
          end else begin
            // Result is in EX now; EX_MulDiv still reflects the finishing op
            // and must not retrigger.
            md_done_s   = 1'b1;
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = {MD_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, mul/div occupancy counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      md_cnt_r      <= {MD_W{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
      if (pc_stall_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign PC_Stall      = pc_stall_s;
  assign IF_ID_Stall   = if_id_stall_s;
  assign IF_ID_Flush   = if_id_flush_s;
  assign ID_EX_Bubble  = id_ex_bubble_s;
  assign ID_EX_Stall   = id_ex_stall_s;
  assign EX_MEM_Bubble = ex_mem_bubble_s;
  assign MulDivStart   = md_start_s;
  assign MulDivDone    = md_done_s;
  // The counter only clears on a clock edge, so mask it while reset is held.
  assign StallCount    = rst ? {CNT_W{1'b0}} : stall_count_r;

endmodule
